// File: rtl/change_event_fifo.sv
// Change-event capture FIFO: stores {gap, timestamp, data} on each enabled trigger and
// streams entries out first-word-fall-through on a valid/ready interface.
`timescale 1ns / 1ps

module change_event_fifo #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned TS_W   = 27,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     trigger,
   input  logic [DATA_W-1:0]        data,
   input  logic                     enable,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TS_W+DATA_W:0]     out_data,
   output logic [ADDR_W:0]          level,
   output logic [15:0]              drop_cnt
);

   localparam int unsigned EntryW = 1 + TS_W + DATA_W;
   localparam logic [ADDR_W:0] LevelFull = DEPTH[ADDR_W:0];

   logic [TS_W-1:0]   ts_q;
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   level_q;
   logic [15:0]       drop_cnt_q;
   logic              gap_q;
   logic [EntryW-1:0] mem_q [DEPTH];

   logic full, req, push, pop, drop;

   always_comb begin
      full      = (level_q == LevelFull);
      out_valid = (level_q != '0);
      pop       = out_valid & out_ready;
      req       = trigger & enable;
      // A pop frees the slot in the same cycle, so a full FIFO can still accept.
      push      = req & (~full | pop);
      drop      = req & ~push;
      out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
      level     = level_q;
      drop_cnt  = drop_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
         gap_q      <= 1'b0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         unique case ({push, pop})
            2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
            default: level_q <= level_q;
         endcase
         if (drop) begin
            gap_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end else if (push) begin
            gap_q <= 1'b0;
         end
      end
   end

   // Storage needs no reset: pointers and level define which words are live.
   always_ff @(posedge clk) begin
      if (reset_n && push) mem_q[wr_ptr_q] <= {gap_q, ts_q, data};
   end

endmodule
